// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared encodings for the datapath and its multiplier
package datapath_pkg;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_AND  = 2'b01,
      ALU_NOT  = 2'b10,
      ALU_PASS = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      PCM_BUS   = 2'b00,
      PCM_ADDER = 2'b01,
      PCM_INC   = 2'b10,
      PCM_HOLD  = 2'b11
   } pcmux_e;

   typedef enum logic [1:0] {
      A2_OFF11 = 2'b00,
      A2_OFF9  = 2'b01,
      A2_OFF6  = 2'b10,
      A2_ZERO  = 2'b11
   } addr2mux_e;

   typedef enum logic [1:0] {
      MS_IDLE = 2'b00,
      MS_RUN  = 2'b01,
      MS_DONE = 2'b10
   } mul_state_e;

endpackage

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - unsigned shift-add multiplier, one partial product per cycle
module seq_mul
   import datapath_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CNT_W = $clog2(WIDTH);

   mul_state_e       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_sum;

   // Only the low WIDTH bits of the product are kept, so bits shifted out of the multiplicand are dropped.
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Next-state logic: operands are captured on start so later register changes cannot disturb the product.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      case (state_q)
         MS_IDLE: begin
            if (start_i) begin
               mcand_d  = a_i;
               mplier_d = b_i;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = MS_RUN;
            end
         end
         MS_RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d = acc_sum;
               state_d  = MS_DONE;
            end
         end
         MS_DONE: state_d = MS_IDLE;
         default: state_d = MS_IDLE;
      endcase
   end

   // State register; reset aborts any multiply in flight and clears the held result.
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q  <= MS_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy_o   = (state_q == MS_RUN);
   assign done_o   = (state_q == MS_DONE);
   assign result_o = result_q;

endmodule

// File: rtl/datapath_p.sv
// rtl/datapath_p.sv - single-bus processor datapath with register file, ALU and multiplier
module datapath_p
   import datapath_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LED_W = 12
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             LD_MAR,
   input  logic             LD_MDR,
   input  logic             LD_IR,
   input  logic             LD_BEN,
   input  logic             LD_CC,
   input  logic             LD_REG,
   input  logic             LD_PC,
   input  logic             LD_LED,
   input  logic             GatePC,
   input  logic             GateMDR,
   input  logic             GateALU,
   input  logic             GateMARMUX,
   input  logic             GateMUL,
   input  logic             ADDR1MUX,
   input  logic             DRMUX,
   input  logic             SR1MUX,
   input  logic             SR2MUX,
   input  logic             MIO_EN,
   input  logic [1:0]       PCMUX,
   input  logic [1:0]       ADDR2MUX,
   input  logic [1:0]       ALUK,
   input  logic [WIDTH-1:0] MDR_In,
   input  logic             MUL_START,
   output logic [WIDTH-1:0] MAR_OUT,
   output logic [WIDTH-1:0] MDR_OUT,
   output logic [WIDTH-1:0] IR_OUT,
   output logic [WIDTH-1:0] PC_OUT,
   output logic             BEN_OUT,
   output logic [LED_W-1:0] LED,
   output logic             MUL_BUSY,
   output logic             MUL_DONE,
   output logic             BUS_ERR
);

   logic [WIDTH-1:0] pc_q, pc_d, mar_q, mdr_q, ir_q;
   logic [WIDTH-1:0] regs_q [8];
   logic [LED_W-1:0] led_q;
   logic [2:0]       nzp_q, nzp_d;
   logic             ben_q, bus_err_q;

   logic [2:0]       dr_sel, sr1_sel, sr2_sel;
   logic [WIDTH-1:0] imm5, off6, off9, off11;
   logic [WIDTH-1:0] sr1_val, sr2_val, alu_b, alu_res;
   logic [WIDTH-1:0] addr1, addr2, adder, mul_res, bus;
   logic [4:0]       gates;
   logic             multi_gate;

   // Instruction fields always come from the low 16 bits of IR, whatever WIDTH is.
   assign dr_sel  = DRMUX  ? ir_q[11:9] : 3'd7;
   assign sr1_sel = SR1MUX ? ir_q[8:6]  : ir_q[11:9];
   assign sr2_sel = ir_q[2:0];
   assign imm5    = {{(WIDTH-5){ir_q[4]}},   ir_q[4:0]};
   assign off6    = {{(WIDTH-6){ir_q[5]}},   ir_q[5:0]};
   assign off9    = {{(WIDTH-9){ir_q[8]}},   ir_q[8:0]};
   assign off11   = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};

   assign sr1_val = regs_q[sr1_sel];
   assign sr2_val = regs_q[sr2_sel];
   assign alu_b   = SR2MUX ? imm5 : sr2_val;
   assign addr1   = ADDR1MUX ? pc_q : sr1_val;
   assign adder   = addr1 + addr2;

   // A non-zero value with more than one bit set means two or more drivers asked for the bus.
   assign gates      = {GateMUL, GateMARMUX, GateALU, GateMDR, GatePC};
   assign multi_gate = (gates != 5'b0) && ((gates & (gates - 5'd1)) != 5'b0);

   // ALU operation select.
   always_comb begin
      alu_res = '0;
      case (alu_op_e'(ALUK))
         ALU_ADD:  alu_res = sr1_val + alu_b;
         ALU_AND:  alu_res = sr1_val & alu_b;
         ALU_NOT:  alu_res = ~sr1_val;
         ALU_PASS: alu_res = sr1_val;
         default:  alu_res = '0;
      endcase
   end

   // Second address-adder operand.
   always_comb begin
      addr2 = '0;
      case (addr2mux_e'(ADDR2MUX))
         A2_OFF11: addr2 = off11;
         A2_OFF9:  addr2 = off9;
         A2_OFF6:  addr2 = off6;
         A2_ZERO:  addr2 = '0;
         default:  addr2 = '0;
      endcase
   end

   // Bus driver: a single gate selects its source; none or a conflict leaves the bus at zero.
   always_comb begin
      bus = '0;
      case (gates)
         5'b00001: bus = pc_q;
         5'b00010: bus = mdr_q;
         5'b00100: bus = alu_res;
         5'b01000: bus = adder;
         5'b10000: bus = mul_res;
         default:  bus = '0;
      endcase
   end

   // Next PC source.
   always_comb begin
      pc_d = pc_q;
      case (pcmux_e'(PCMUX))
         PCM_BUS:   pc_d = bus;
         PCM_ADDER: pc_d = adder;
         PCM_INC:   pc_d = pc_q + WIDTH'(1);
         PCM_HOLD:  pc_d = pc_q;
         default:   pc_d = pc_q;
      endcase
   end

   // Condition codes from the current bus value.
   always_comb begin
      nzp_d = 3'b001;
      if (bus[WIDTH-1])      nzp_d = 3'b100;
      else if (bus == '0)    nzp_d = 3'b010;
   end

   // Architectural registers; BEN samples nzp_q so a same-edge CC load is not yet visible.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         pc_q      <= '0;
         mar_q     <= '0;
         mdr_q     <= '0;
         ir_q      <= '0;
         led_q     <= '0;
         nzp_q     <= 3'b000;
         ben_q     <= 1'b0;
         bus_err_q <= 1'b0;
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else begin
         if (LD_PC)  pc_q  <= pc_d;
         if (LD_MAR) mar_q <= bus;
         if (LD_MDR) mdr_q <= MIO_EN ? MDR_In : bus;
         if (LD_IR)  ir_q  <= bus;
         if (LD_LED) led_q <= ir_q[LED_W-1:0];
         if (LD_CC)  nzp_q <= nzp_d;
         if (LD_BEN) ben_q <= |(ir_q[11:9] & nzp_q);
         if (LD_REG) regs_q[dr_sel] <= bus;
         bus_err_q <= bus_err_q | multi_gate;
      end
   end

   seq_mul #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk_i    (Clk),
      .resetn_i (Reset_n),
      .start_i  (MUL_START),
      .a_i      (sr1_val),
      .b_i      (alu_b),
      .busy_o   (MUL_BUSY),
      .done_o   (MUL_DONE),
      .result_o (mul_res)
   );

   assign MAR_OUT = mar_q;
   assign MDR_OUT = mdr_q;
   assign IR_OUT  = ir_q;
   assign PC_OUT  = pc_q;
   assign BEN_OUT = ben_q;
   assign LED     = led_q;
   assign BUS_ERR = bus_err_q;

endmodule

// File: tb/tb_datapath_p.sv
// tb/tb_datapath_p.sv - self-checking bench for datapath_p at WIDTH 16 and 32
module tb_datapath_p;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic Reset_n;
   logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
   logic GatePC, GateMDR, GateALU, GateMARMUX, GateMUL;
   logic ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN, MUL_START;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   logic [15:0] MDR_In;
   logic [31:0] MDR_In32;

   logic [15:0] mar16, mdr16, ir16, pc16;
   logic [31:0] mar32, mdr32, ir32, pc32;
   logic [11:0] led16, led32;
   logic ben16, busy16, done16, err16;
   logic ben32, busy32, done32, err32;

   int passed = 0;
   int total  = 0;

   datapath_p #(.WIDTH(16), .LED_W(12)) dut16 (
      .Clk(Clk), .Reset_n(Reset_n),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
      .GateMARMUX(GateMARMUX), .GateMUL(GateMUL),
      .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
      .MIO_EN(MIO_EN), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
      .MDR_In(MDR_In), .MUL_START(MUL_START),
      .MAR_OUT(mar16), .MDR_OUT(mdr16), .IR_OUT(ir16), .PC_OUT(pc16),
      .BEN_OUT(ben16), .LED(led16), .MUL_BUSY(busy16), .MUL_DONE(done16),
      .BUS_ERR(err16)
   );

   datapath_p #(.WIDTH(32), .LED_W(12)) dut32 (
      .Clk(Clk), .Reset_n(Reset_n),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
      .GateMARMUX(GateMARMUX), .GateMUL(GateMUL),
      .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
      .MIO_EN(MIO_EN), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
      .MDR_In(MDR_In32), .MUL_START(MUL_START),
      .MAR_OUT(mar32), .MDR_OUT(mdr32), .IR_OUT(ir32), .PC_OUT(pc32),
      .BEN_OUT(ben32), .LED(led32), .MUL_BUSY(busy32), .MUL_DONE(done32),
      .BUS_ERR(err32)
   );

   // Reference model of the 16-bit machine (architectural view only).
   logic [15:0] m_pc, m_mar, m_mdr, m_ir, m_mul;
   logic [15:0] m_reg [8];
   logic [11:0] m_led;
   logic [2:0]  m_nzp;
   logic        m_ben, m_err;

   function automatic logic [15:0] sx(input logic [15:0] v, input int n);
      int x;
      x = int'(v) & ((1 << n) - 1);
      if (x >= (1 << (n - 1))) x = x - (1 << n);
      return 16'(x);
   endfunction

   task automatic model_step();
      int ng;
      logic [2:0]  s1, dr;
      logic [15:0] sr1, b, alu, a1, a2, add, bus, pcn;
      if (!Reset_n) begin
         m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_mul = 0; m_led = 0;
         m_nzp = 0; m_ben = 0; m_err = 0;
         for (int i = 0; i < 8; i++) m_reg[i] = 0;
         return;
      end
      s1  = SR1MUX ? m_ir[8:6] : m_ir[11:9];
      sr1 = m_reg[s1];
      b   = SR2MUX ? sx(m_ir, 5) : m_reg[m_ir[2:0]];
      case (ALUK)
         2'd0: alu = sr1 + b;
         2'd1: alu = sr1 & b;
         2'd2: alu = ~sr1;
         default: alu = sr1;
      endcase
      a1 = ADDR1MUX ? m_pc : sr1;
      case (ADDR2MUX)
         2'd0: a2 = sx(m_ir, 11);
         2'd1: a2 = sx(m_ir, 9);
         2'd2: a2 = sx(m_ir, 6);
         default: a2 = 0;
      endcase
      add = a1 + a2;
      ng = int'(GatePC) + int'(GateMDR) + int'(GateALU) + int'(GateMARMUX) + int'(GateMUL);
      bus = 0;
      if (ng == 1) bus = GatePC ? m_pc : GateMDR ? m_mdr : GateALU ? alu : GateMARMUX ? add : m_mul;
      if (ng > 1) m_err = 1;
      case (PCMUX)
         2'd0: pcn = bus;
         2'd1: pcn = add;
         2'd2: pcn = m_pc + 16'd1;
         default: pcn = m_pc;
      endcase
      dr = DRMUX ? m_ir[11:9] : 3'd7;
      if (LD_BEN) m_ben = |(m_ir[11:9] & m_nzp);
      if (LD_LED) m_led = m_ir[11:0];
      if (LD_REG) m_reg[dr] = bus;
      if (LD_CC)  m_nzp = bus[15] ? 3'b100 : (bus == 0) ? 3'b010 : 3'b001;
      if (LD_IR)  m_ir = bus;
      if (LD_MAR) m_mar = bus;
      if (LD_MDR) m_mdr = MIO_EN ? MDR_In : bus;
      if (LD_PC)  m_pc = pcn;
   endtask

   task automatic tick();
      model_step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_ctl();
      Reset_n = 1; MUL_START = 0;
      LD_MAR = 0; LD_MDR = 0; LD_IR = 0; LD_BEN = 0; LD_CC = 0; LD_REG = 0; LD_PC = 0; LD_LED = 0;
      GatePC = 0; GateMDR = 0; GateALU = 0; GateMARMUX = 0; GateMUL = 0;
      ADDR1MUX = 0; DRMUX = 0; SR1MUX = 0; SR2MUX = 0; MIO_EN = 0;
      PCMUX = 0; ADDR2MUX = 0; ALUK = 0; MDR_In = 0; MDR_In32 = 0;
   endtask

   task automatic do_reset();
      clear_ctl(); Reset_n = 0; tick(); Reset_n = 1;
   endtask

   task automatic load_mdr(input logic [15:0] v, input logic [31:0] v32);
      clear_ctl(); MDR_In = v; MDR_In32 = v32; MIO_EN = 1; LD_MDR = 1; tick(); clear_ctl();
   endtask

   task automatic set_ir(input logic [15:0] v);
      load_mdr(v, {16'h0, v}); GateMDR = 1; LD_IR = 1; tick(); clear_ctl();
   endtask

   task automatic write_dr(input logic [15:0] v, input logic [31:0] v32);
      load_mdr(v, v32); GateMDR = 1; LD_REG = 1; DRMUX = 1; tick(); clear_ctl();
   endtask

   task automatic test_reset();
      clear_ctl();
      Reset_n = 0; LD_PC = 1; PCMUX = 2; LD_MAR = 1; GatePC = 1; MUL_START = 1; LD_LED = 1;
      tick(); clear_ctl();
      total++;
      if ({pc16, mar16, mdr16, ir16} !== 64'h0) $display("FAIL reset_regs: got %h required 0", {pc16, mar16, mdr16, ir16});
      else passed++;
      total++;
      if ({ben16, led16, err16, busy16, done16} !== 16'h0) $display("FAIL reset_flags: got %h required 0", {ben16, led16, err16, busy16, done16});
      else passed++;
   endtask

   task automatic test_pc();
      do_reset();
      LD_PC = 1; PCMUX = 2;
      repeat (3) tick();
      total++;
      if (pc16 !== 16'd3) $display("FAIL pc_inc3: got %h required 0003", pc16); else passed++;
      PCMUX = 3; tick();
      total++;
      if (pc16 !== 16'd3) $display("FAIL pc_hold: got %h required 0003", pc16); else passed++;
      load_mdr(16'hFFFF, 32'hFFFF_FFFF);
      GateMDR = 1; LD_PC = 1; PCMUX = 0; tick(); clear_ctl();
      total++;
      if (pc16 !== 16'hFFFF) $display("FAIL pc_from_bus: got %h required ffff", pc16); else passed++;
      LD_PC = 1; PCMUX = 2; tick(); clear_ctl();
      total++;
      if ({pc16, pc32} !== 48'h0) $display("FAIL pc_wrap: got %h/%h required 0/0", pc16, pc32); else passed++;
   endtask

   task automatic test_random();
      int g;
      do_reset();
      for (int c = 0; c < 300; c++) begin
         clear_ctl();
         Reset_n = ($urandom % 60) != 0;
         LD_MAR = 1'($urandom); LD_MDR = 1'($urandom); LD_IR = 1'($urandom); LD_BEN = 1'($urandom);
         LD_CC = 1'($urandom); LD_REG = 1'($urandom); LD_PC = 1'($urandom); LD_LED = 1'($urandom);
         ADDR1MUX = 1'($urandom); DRMUX = 1'($urandom); SR1MUX = 1'($urandom); SR2MUX = 1'($urandom);
         MIO_EN = 1'($urandom); PCMUX = 2'($urandom); ADDR2MUX = 2'($urandom); ALUK = 2'($urandom);
         MDR_In = 16'($urandom); MDR_In32 = $urandom;
         g = $urandom % 9;
         case (g)
            0: GatePC = 1;
            1: GateMDR = 1;
            2, 7: GateALU = 1;
            3, 8: GateMARMUX = 1;
            4: GateMUL = 1;
            5: ;
            default: begin GateALU = 1; GateMDR = ($urandom % 2) == 0; GatePC = !GateMDR; end
         endcase
         tick();
         total++;
         if ({pc16, mar16, mdr16, ir16, ben16, led16, err16} !== {m_pc, m_mar, m_mdr, m_ir, m_ben, m_led, m_err})
            $display("FAIL random_cycle%0d: got pc=%h mar=%h mdr=%h ir=%h ben=%b led=%h err=%b required pc=%h mar=%h mdr=%h ir=%h ben=%b led=%h err=%b",
                     c, pc16, mar16, mdr16, ir16, ben16, led16, err16, m_pc, m_mar, m_mdr, m_ir, m_ben, m_led, m_err);
         else passed++;
      end
      clear_ctl();
   endtask

   task automatic test_mul();
      int n;
      do_reset();
      set_ir(16'h0400); write_dr(16'd6, 32'd6);
      set_ir(16'h0202); write_dr(16'd7, 32'd7);
      MUL_START = 1; tick();
      n = 0;
      while (busy16 === 1'b1 && n < 100) begin
         n++;
         // overwrite R1 mid-run; the captured operand must be unaffected
         clear_ctl(); MUL_START = 1; GatePC = 1; LD_REG = 1; DRMUX = 1;
         tick();
      end
      total++;
      if (n != 16) $display("FAIL mul_busy_cycles: got %0d required 16", n); else passed++;
      total++;
      if ({done16, busy16} !== 2'b10) $display("FAIL mul_done_pulse: got done=%b busy=%b required done=1 busy=0", done16, busy16); else passed++;
      clear_ctl(); MUL_START = 1; tick(); clear_ctl();
      total++;
      if ({done16, busy16} !== 2'b00) $display("FAIL mul_start_in_done: got done=%b busy=%b required 0 0", done16, busy16); else passed++;
      GateMUL = 1; LD_MAR = 1; tick(); clear_ctl();
      total++;
      if (mar16 !== 16'h002A) $display("FAIL mul_7x6: got %h required 002a", mar16); else passed++;
   endtask

   task automatic test_mul_random();
      int n;
      logic [15:0] a, b, bop, expv;
      logic [4:0]  imm;
      for (int k = 0; k < 6; k++) begin
         a = 16'($urandom); b = 16'($urandom); imm = 5'($urandom);
         set_ir(16'h0400); write_dr(b, {16'h0, b});
         if (k % 2 == 1) begin
            set_ir({11'b0000_001_0000, imm}); bop = sx({11'b0, imm}, 5);
         end else begin
            set_ir(16'h0202); bop = b;
         end
         write_dr(a, {16'h0, a});
         expv = a * bop;
         SR2MUX = (k % 2 == 1); MUL_START = 1; tick(); clear_ctl();
         n = 0;
         while (busy16 === 1'b1 && n < 100) begin n++; tick(); end
         tick();
         GateMUL = 1; LD_MAR = 1; tick(); clear_ctl();
         total++;
         if (mar16 !== expv || n != 16)
            $display("FAIL mul_random%0d: %h*%h got %h in %0d cycles required %h in 16", k, a, bop, mar16, n, expv);
         else passed++;
      end
   endtask

   task automatic test_bus_err();
      do_reset();
      LD_PC = 1; PCMUX = 2; repeat (2) tick(); clear_ctl();
      GatePC = 1; LD_MAR = 1; tick(); clear_ctl();
      total++;
      if ({mar16, err16} !== {16'd2, 1'b0}) $display("FAIL single_gate: got mar=%h err=%b required 0002 0", mar16, err16); else passed++;
      GatePC = 1; GateALU = 1; LD_MAR = 1; tick(); clear_ctl();
      total++;
      if ({mar16, err16} !== {16'd0, 1'b1}) $display("FAIL double_gate: got mar=%h err=%b required 0000 1", mar16, err16); else passed++;
      repeat (4) tick();
      total++;
      if (err16 !== 1'b1) $display("FAIL bus_err_sticky: got %b required 1", err16); else passed++;
      do_reset();
      total++;
      if (err16 !== 1'b0) $display("FAIL bus_err_reset: got %b required 0", err16); else passed++;
   endtask

   task automatic test_cc_ben();
      do_reset();
      set_ir(16'h0800);
      load_mdr(16'h8000, 32'h8000);
      GateMDR = 1; LD_CC = 1; tick(); clear_ctl();
      LD_BEN = 1; tick(); clear_ctl();
      total++;
      if (ben16 !== 1'b1) $display("FAIL ben_n_match: got %b required 1", ben16); else passed++;
      set_ir(16'h0600);
      LD_BEN = 1; tick(); clear_ctl();
      total++;
      if (ben16 !== 1'b0) $display("FAIL ben_n_nomatch: got %b required 0", ben16); else passed++;
      set_ir(16'h0800);
      LD_CC = 1; LD_BEN = 1; tick(); clear_ctl();
      total++;
      if (ben16 !== 1'b1) $display("FAIL ben_old_nzp: got %b required 1", ben16); else passed++;
      LD_BEN = 1; tick(); clear_ctl();
      total++;
      if (ben16 !== 1'b0) $display("FAIL ben_new_nzp: got %b required 0", ben16); else passed++;
   endtask

   task automatic test_mul_reset();
      int n;
      int dones;
      do_reset();
      set_ir(16'h0400); write_dr(16'd3, 32'd3);
      set_ir(16'h0202); write_dr(16'd5, 32'd5);
      MUL_START = 1; tick(); clear_ctl();
      n = 0;
      while (busy16 === 1'b1 && n < 100) begin n++; tick(); end
      tick();
      GateMUL = 1; LD_MAR = 1; tick(); clear_ctl();
      total++;
      if (mar16 !== 16'd15) $display("FAIL mul_5x3: got %h required 000f", mar16); else passed++;
      MUL_START = 1; tick(); clear_ctl();
      repeat (4) tick();
      Reset_n = 0; tick(); clear_ctl();
      total++;
      if ({busy16, done16} !== 2'b00) $display("FAIL mul_abort: got busy=%b done=%b required 0 0", busy16, done16); else passed++;
      dones = 0;
      for (int c = 0; c < 24; c++) begin tick(); if (done16 !== 1'b0) dones++; end
      total++;
      if (dones != 0) $display("FAIL mul_abort_no_done: got %0d pulses required 0", dones); else passed++;
      load_mdr(16'hBEEF, 32'hBEEF);
      GateMDR = 1; LD_MAR = 1; tick(); clear_ctl();
      GateMUL = 1; LD_MAR = 1; tick(); clear_ctl();
      total++;
      if (mar16 !== 16'h0) $display("FAIL mul_result_cleared: got %h required 0000", mar16); else passed++;
   endtask

   task automatic test_w32();
      int n;
      do_reset();
      set_ir(16'h0201);
      write_dr(16'hFFFF, 32'hFFFF_FFFF);
      SR2MUX = 1; ALUK = 0; GateALU = 1; LD_MAR = 1; tick(); clear_ctl();
      total++;
      if ({mar32, mar16} !== 48'h0) $display("FAIL alu_add_wrap: got %h/%h required 0/0", mar32, mar16); else passed++;
      set_ir(16'h0400); write_dr(16'h0, 32'h0001_0000);
      set_ir(16'h0202); write_dr(16'h0, 32'h0001_0000);
      MUL_START = 1; tick(); clear_ctl();
      n = 0;
      while (busy32 === 1'b1 && n < 100) begin n++; tick(); end
      total++;
      if (n != 32 || done32 !== 1'b1) $display("FAIL mul32_timing: got %0d cycles done=%b required 32 1", n, done32); else passed++;
      tick();
      load_mdr(16'h1234, 32'h1234_5678);
      GateMDR = 1; LD_MAR = 1; tick(); clear_ctl();
      GateMUL = 1; LD_MAR = 1; tick(); clear_ctl();
      total++;
      if (mar32 !== 32'h0) $display("FAIL mul32_overflow: got %h required 00000000", mar32); else passed++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clear_ctl();
      test_reset();
      test_pc();
      test_random();
      test_mul();
      test_mul_random();
      test_bus_err();
      test_cc_ben();
      test_mul_reset();
      test_w32();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/datapath_p.md
DATAPATH_P -- requirements
Module: datapath_p

Interface
REQ-001 Parameter WIDTH, default 16, data/bus/register width; legal values 16..32.
REQ-002 Parameter LED_W, default 12, LED register width; legal values 1..12.
REQ-003 Clk  input  1  sole clock; all state updates on posedge.
REQ-004 Reset_n  input  1  synchronous, active-low reset.
REQ-005 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  input  1 each  register load enables.
REQ-006 GatePC, GateMDR, GateALU, GateMARMUX, GateMUL  input  1 each  bus drive requests.
REQ-007 ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN  input  1 each  mux selects.
REQ-008 PCMUX, ADDR2MUX, ALUK  input  2 each  mux/operation selects.
REQ-009 MDR_In  input  WIDTH  memory read data.
REQ-010 MUL_START  input  1  multiply request.
REQ-011 MAR_OUT, MDR_OUT, IR_OUT, PC_OUT  output  WIDTH each  register contents.
REQ-012 BEN_OUT  output  1  branch enable.
REQ-013 LED  output  LED_W  LED register.
REQ-014 MUL_BUSY  output  1  multiplier running; MUL_DONE  output  1  one-cycle completion pulse.
REQ-015 BUS_ERR  output  1  sticky multiple-gate error.

Function
REQ-016 Bus: exactly one gate high -> bus = PC, MDR, ALU result, address-adder result or MUL result respectively; no gate -> bus = 0; two or more -> bus = 0 and BUS_ERR set next edge.
REQ-017 IR fields always taken from IR_OUT[15:0]; immediates/offsets (imm5, off6, off9, off11) sign-extended to WIDTH.
REQ-018 Adder = ADDR1 + ADDR2 modulo 2^WIDTH; ADDR1MUX 0 = SR1, 1 = PC; ADDR2MUX 00 = off11, 01 = off9, 10 = off6, 11 = 0.
REQ-019 PCMUX 00 = bus, 01 = adder, 10 = PC+1 (wraps all-ones -> 0), 11 = PC unchanged; PC loads only when LD_PC.
REQ-020 Register file: 8 x WIDTH, combinational reads; DRMUX 0 -> R7, 1 -> IR[11:9]; SR1MUX 0 -> IR[11:9], 1 -> IR[8:6]; SR2 = IR[2:0]; write bus to DR on LD_REG.
REQ-021 SR2MUX 0 = SR2 register, 1 = sext imm5.
REQ-022 ALUK 00 = ADD (mod 2^WIDTH), 01 = AND, 10 = NOT SR1, 11 = pass SR1.
REQ-023 On LD_CC: NZP <= 100 if bus[WIDTH-1], 010 if bus == 0, else 001.
REQ-024 On LD_BEN: BEN <= |(IR[11:9] & NZP) using NZP value before same-edge LD_CC update.
REQ-025 MAR, IR load bus; MDR loads MDR_In when MIO_EN = 1, else bus; LED loads IR[LED_W-1:0] on LD_LED.
REQ-026 Multiplier FSM states IDLE, RUN, DONE: IDLE + MUL_START -> capture SR1 and SR2MUX operands, RUN.
REQ-027 RUN lasts exactly WIDTH cycles (MUL_BUSY = 1), shift-add unsigned, result = low WIDTH bits of product.
REQ-028 DONE lasts one cycle (MUL_DONE = 1, MUL_BUSY = 0), then IDLE; MUL_START in DONE is ignored.
REQ-029 MUL_START during RUN or DONE ignored; result register holds last product until next completion.
REQ-030 Register/operand changes during RUN do not affect the product.

Reset
REQ-031 Reset_n low at posedge: PC, MAR, MDR, IR, R0-R7, LED, result register = 0; NZP = 000; BEN = 0; BUS_ERR = 0; FSM -> IDLE.
REQ-032 Reset has priority over all loads and MUL_START; reset during RUN aborts, MUL_DONE not pulsed.

Structure
REQ-033 Package datapath_pkg holds ALU op, PCMUX, ADDR2MUX encodings and multiplier state enum.
REQ-034 Multiplier is sub-module seq_mul (WIDTH parameter, start/busy/done/result); all else in datapath_p.

Verification
REQ-035 Reset, LD_PC with PCMUX=10 for 3 cycles -> PC_OUT = 3; PCMUX=11 with LD_PC -> PC stays 3.
REQ-036 R1=7, R2=6 via bus, SR1=R1, SR2MUX=0, MUL_START -> MUL_BUSY 16 cycles, MUL_DONE one cycle, GateMUL bus = 0x002A.
REQ-037 GatePC and GateALU together one cycle -> bus = 0, BUS_ERR = 1 and stays 1 until Reset_n low.
REQ-038 Bus = 0x8000 with LD_CC -> NZP = 100; IR[11:9] = 100, LD_BEN -> BEN_OUT = 1; IR[11:9] = 011 -> BEN_OUT = 0.
REQ-039 Reset_n low at RUN cycle 5 -> MUL_BUSY = 0 next cycle, no MUL_DONE, result reads 0.
REQ-040 WIDTH=32: R1=0xFFFFFFFF, imm5=1, ALUK=00 -> ALU result 0; MUL 0x10000 x 0x10000 -> 0.
